// File: rtl/vj_pkg.sv
// Shared types for the Viola-Jones window-scan scheduler: FSM state
// encoding, default window edge, and the coordinate record carried
// alongside each window through the cascade latency.
package vj_pkg;

    localparam int VJ_WINDOW_DEF = 24;
    localparam int VJ_IDX_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUILD = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } vj_state_t;

    typedef struct packed {
        logic                valid;
        logic [3:0]          level;
        logic [VJ_IDX_W-1:0] row;
        logic [VJ_IDX_W-1:0] col;
    } vj_coord_t;

endpackage

// File: rtl/vj_coord_delay.sv
// Fixed-latency delay line for window coordinate records. The head record
// lines up with the cascade verdict for the same window. A synchronous
// clear drops every in-flight record so late verdicts find no valid head.
module vj_coord_delay
    import vj_pkg::*;
#(
    parameter int PIPE_DEPTH = 26
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      clear,
    input  vj_coord_t entry,
    output vj_coord_t head
);

    vj_coord_t stage [PIPE_DEPTH];

    // Shift one record per cycle; reset or clear invalidates every stage.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage[i].valid <= 1'b0;
            end
        end else begin
            stage[0] <= entry;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head = stage[PIPE_DEPTH-1];

endmodule

// File: rtl/vj_scan_ctrl.sv
// Window-scan scheduler: walks every pyramid level, requests each scaled
// level, issues one window per cycle to the cascade, and matches verdicts
// back to window coordinates through vj_coord_delay.
// Optional build macro VJ_FIRST_FACE_STOP_EN: stop the whole scan on the
// first reported face and drop any verdicts still in flight.
module vj_scan_ctrl
    import vj_pkg::*;
#(
    parameter int NUM_PYRAMIDS = 7,
    parameter int WINDOW       = VJ_WINDOW_DEF,
    parameter int PIPE_DEPTH   = 26,
    parameter int IDX_W        = VJ_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             laptop_img_rdy,
    output logic             pyr_start,
    input  logic             pyr_ready,
    input  logic [IDX_W-1:0] level_width,
    input  logic [IDX_W-1:0] level_height,
    output logic [3:0]       pyramid_number,
    output logic [IDX_W-1:0] row_index,
    output logic [IDX_W-1:0] col_index,
    output logic             win_valid,
    input  logic             is_face,
    output logic [1:0][31:0] face_coords,
    output logic [3:0]       face_pyramid,
    output logic             face_coords_ready,
    output logic             scan_done,
    output logic             busy
);

    localparam int               CNT_W      = $clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [3:0]       LAST_LEVEL = 4'(NUM_PYRAMIDS - 1);
    localparam logic [IDX_W-1:0] WIN        = IDX_W'(WINDOW);

    vj_state_t        state;
    vj_state_t        next_state;
    logic             req_sent;
    logic             stop_flag;
    logic             stop_now;
    logic             level_ok;
    logic             scan_last;
    logic             head_hit;
    logic [IDX_W-1:0] col_max;
    logic [IDX_W-1:0] row_max;
    logic [CNT_W-1:0] drain_cnt;
    vj_coord_t        entry;
    vj_coord_t        head;

    // Handshakes: pyr_start is a one-cycle request on BUILD entry; pyr_ready
    // only counts in BUILD after that request; win_valid marks each issued
    // window; is_face is only meaningful while the delay-line head is valid.
    assign level_ok  = (level_width >= WIN) && (level_height >= WIN);
    assign scan_last = (col_index == col_max) && (row_index == row_max);
    assign head_hit  = head.valid && is_face;

`ifdef VJ_FIRST_FACE_STOP_EN
    assign stop_now = head_hit;
`else
    assign stop_now = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (laptop_img_rdy) next_state = ST_BUILD;
            ST_BUILD: if (req_sent && pyr_ready) next_state = level_ok ? ST_SCAN : ST_NEXT;
            ST_SCAN: begin
                if (stop_now)       next_state = ST_NEXT;
                else if (scan_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (stop_now || drain_cnt == DRAIN_LAST) next_state = ST_NEXT;
            end
            ST_NEXT:  next_state = (stop_flag || pyramid_number == LAST_LEVEL) ? ST_DONE : ST_BUILD;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state != ST_IDLE);
        pyr_start = (state == ST_BUILD) && !req_sent;
        win_valid = (state == ST_SCAN);
        scan_done = (state == ST_DONE);
    end

    // Scan counters, level bookkeeping and face result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_sent          <= 1'b0;
            stop_flag         <= 1'b0;
            pyramid_number    <= '0;
            row_index         <= '0;
            col_index         <= '0;
            col_max           <= '0;
            row_max           <= '0;
            drain_cnt         <= '0;
            face_coords       <= '0;
            face_pyramid      <= '0;
            face_coords_ready <= 1'b0;
        end else begin
            req_sent <= (state == ST_BUILD) && (next_state == ST_BUILD);
            case (state)
                ST_IDLE: begin
                    if (laptop_img_rdy) begin
                        pyramid_number <= '0;
                        stop_flag      <= 1'b0;
                    end
                end
                ST_BUILD: begin
                    if (req_sent && pyr_ready) begin
                        col_max   <= level_width - WIN;
                        row_max   <= level_height - WIN;
                        row_index <= '0;
                        col_index <= '0;
                    end
                end
                ST_SCAN: begin
                    drain_cnt <= '0;
                    if (col_index == col_max) begin
                        col_index <= '0;
                        if (!scan_last) row_index <= row_index + 1'b1;
                    end else begin
                        col_index <= col_index + 1'b1;
                    end
                end
                ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                ST_NEXT: begin
                    if (next_state == ST_BUILD) pyramid_number <= pyramid_number + 1'b1;
                end
                default: ;
            endcase
            if (stop_now) stop_flag <= 1'b1;
            face_coords_ready <= head_hit;
            if (head_hit) begin
                face_coords[0] <= 32'(head.row);
                face_coords[1] <= 32'(head.col);
                face_pyramid   <= head.level;
            end
        end
    end

    // Coordinate record for the window issued this cycle.
    always_comb begin
        entry       = '0;
        entry.valid = win_valid;
        entry.level = pyramid_number;
        entry.row   = row_index;
        entry.col   = col_index;
    end

    vj_coord_delay #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_coord_delay (
        .clock(clock),
        .reset(reset),
        .clear(stop_now),
        .entry(entry),
        .head (head)
    );

endmodule

// File: tb/tb_vj_scan_ctrl.sv
// Bench for vj_scan_ctrl with two pyramid levels: level 0 size comes from a
// vector table, level 1 is always 20x30 (no windows). A cascade model drives
// is_face PIPE_DEPTH cycles after chosen windows; a scoreboard checks window
// order, face reports and their timing, and level/scan sequencing.
module tb_vj_scan_ctrl;

  localparam int D   = 26;
  localparam int WIN = 24;
`ifdef VJ_FIRST_FACE_STOP_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             laptop_img_rdy;
  logic             pyr_start;
  logic             pyr_ready;
  logic [9:0]       level_width;
  logic [9:0]       level_height;
  logic [3:0]       pyramid_number;
  logic [9:0]       row_index;
  logic [9:0]       col_index;
  logic             win_valid;
  logic             is_face;
  logic [1:0][31:0] face_coords;
  logic [3:0]       face_pyramid;
  logic             face_coords_ready;
  logic             scan_done;
  logic             busy;

  vj_scan_ctrl #(.NUM_PYRAMIDS(2), .WINDOW(WIN), .PIPE_DEPTH(D), .IDX_W(10)) dut (
    .clock(clock), .reset(reset), .laptop_img_rdy(laptop_img_rdy),
    .pyr_start(pyr_start), .pyr_ready(pyr_ready),
    .level_width(level_width), .level_height(level_height),
    .pyramid_number(pyramid_number), .row_index(row_index), .col_index(col_index),
    .win_valid(win_valid), .is_face(is_face), .face_coords(face_coords),
    .face_pyramid(face_pyramid), .face_coords_ready(face_coords_ready),
    .scan_done(scan_done), .busy(busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int w;
    int h;
    int f0;
    int f1;
    bit poke;
  } vec_t;

  vec_t        vecs [6];
  logic [19:0] exp_win[$];
  logic [63:0] exp_q[$];
  logic [D:0]  pend;
  int n_vec, n_bad, cyc;
  int win_seen, tgt0, tgt1, ncols_g, last_win_cyc, face_cyc, pyr_starts;
  bit stop_run, first_pushed, force_face;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs at negedge, score them, then drive the cascade.
  task automatic step();
    bit drive_hit;
    logic [19:0] e;
    logic [63:0] f;
    @(negedge clock);
    cyc++;
    drive_hit = 1'b0;
    if (win_valid) begin
      if (exp_win.size() == 0) chk("extra_window", 1, 0);
      else begin
        e = exp_win.pop_front();
        chk("window", {row_index, col_index}, e);
      end
      chk("win_level", pyramid_number, 0);
      drive_hit = (win_seen == tgt0) || (win_seen == tgt1);
      if (drive_hit && !(stop_run && first_pushed)) begin
        exp_q.push_back({32'(cyc + D + 1), 16'(win_seen / ncols_g), 16'(win_seen % ncols_g)});
        if (!first_pushed) face_cyc = cyc;
        first_pushed = 1'b1;
      end
      win_seen++;
      last_win_cyc = cyc;
    end
    if (face_coords_ready) begin
      if (exp_q.size() == 0) chk("extra_face", 1, 0);
      else begin
        f = exp_q.pop_front();
        chk("face_cycle", cyc, 64'(f[63:32]));
        chk("face_row", face_coords[0], 64'(f[31:16]));
        chk("face_col", face_coords[1], 64'(f[15:0]));
        chk("face_level", face_pyramid, 0);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][63:32]) <= cyc) begin
      chk("face_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (pyr_start) pyr_starts++;
    pend = {pend[D-1:0], drive_hit};
    is_face = pend[D] | force_face;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pyr_start"}, pyr_start, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_row"}, row_index, 0);
    chk({tag, "_col"}, col_index, 0);
    chk({tag, "_level"}, pyramid_number, 0);
    chk({tag, "_face_coords"}, face_coords, 0);
    chk({tag, "_face_pyr"}, face_pyramid, 0);
    chk({tag, "_face_rdy"}, face_coords_ready, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
  endtask

  // Driver: full two-level scan with level 0 = v.w x v.h.
  task automatic run_scan(input vec_t v);
    int nrows, nwin, nexp, ff, budget;
    bit poked;
    ncols_g = (v.w >= WIN) ? v.w - WIN + 1 : 0;
    nrows   = (v.h >= WIN) ? v.h - WIN + 1 : 0;
    nwin    = ncols_g * nrows;
    ff = -1;
    if (v.f0 >= 0) ff = v.f0;
    if (v.f1 >= 0 && (ff < 0 || v.f1 < ff)) ff = v.f1;
    stop_run = STOP_MODE && (ff >= 0);
    nexp = nwin;
    if (stop_run && ff + D + 1 < nwin) nexp = ff + D + 1;
    exp_win.delete();
    for (int i = 0; i < nexp; i++) exp_win.push_back({10'(i / ncols_g), 10'(i % ncols_g)});
    tgt0 = v.f0; tgt1 = v.f1; win_seen = 0; pyr_starts = 0;
    first_pushed = 1'b0; last_win_cyc = 0; poked = 1'b0;

    laptop_img_rdy = 1'b1; step(); laptop_img_rdy = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_pyr_start", pyr_start, 1);
    chk("start_level", pyramid_number, 0);
    step();
    chk("pyr_start_pulse", pyr_start, 0);
    step(); step();
    pyr_ready = 1'b1; level_width = 10'(v.w); level_height = 10'(v.h);
    step();
    pyr_ready = 1'b0;
    chk("first_win", win_valid, nwin > 0);
    budget = 400;
    while (!pyr_start && !scan_done && budget > 0) begin
      if (v.poke && !poked && win_seen == 2) begin
        poked = 1'b1;
        laptop_img_rdy = 1'b1; pyr_ready = 1'b1; level_width = 10'd50; level_height = 10'd50;
        step();
        laptop_img_rdy = 1'b0; pyr_ready = 1'b0;
      end else begin
        step();
      end
      budget--;
    end
    if (budget == 0) begin
      chk("level0_timeout", 0, 1);
      return;
    end
    if (stop_run) begin
      chk("stop_done", scan_done, 1);
      chk("stop_done_cycle", cyc - face_cyc, D + 2);
      step();
      chk("stop_idle", busy, 0);
    end else begin
      chk("next_pyr_start", pyr_start, 1);
      chk("next_level", pyramid_number, 1);
      if (nwin > 0) chk("drain_len", cyc - last_win_cyc, D + 2);
      step(); step();
      pyr_ready = 1'b1; level_width = 10'd20; level_height = 10'd30;
      step();
      pyr_ready = 1'b0;
      chk("small_no_win", win_valid, 0);
      chk("small_not_done", scan_done, 0);
      step();
      chk("scan_done", scan_done, 1);
      step();
      chk("done_pulse", scan_done, 0);
      chk("end_idle", busy, 0);
    end
    repeat (D + 4) step();
    chk("windows_left", exp_win.size(), 0);
    chk("faces_left", exp_q.size(), 0);
    chk("pyr_start_count", pyr_starts, stop_run ? 1 : 2);
  endtask

  // Reset in the middle of a scan with a verdict in flight.
  task automatic reset_mid_scan();
    int budget;
    ncols_g = 17;
    exp_win.delete();
    for (int i = 0; i < 17 * 7; i++) exp_win.push_back({10'(i / 17), 10'(i % 17)});
    tgt0 = 2; tgt1 = -1; stop_run = 1'b0; first_pushed = 1'b0; win_seen = 0;
    laptop_img_rdy = 1'b1; step(); laptop_img_rdy = 1'b0;
    step(); step();
    pyr_ready = 1'b1; level_width = 10'd40; level_height = 10'd30;
    step();
    pyr_ready = 1'b0;
    budget = 50;
    while (win_seen < 6 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("rst_scan_timeout", 0, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check_zero("mid_rst");
    exp_win.delete(); exp_q.delete(); pend = '0; tgt0 = -1;
    force_face = 1'b1;
    repeat (40) step();
    force_face = 1'b0;
    step();
    chk("post_rst_idle", busy, 0);
  endtask

  initial begin
    vecs[0] = '{w: 26, h: 25, f0: 5,  f1: -1, poke: 1'b0};
    vecs[1] = '{w: 26, h: 25, f0: 1,  f1: 3,  poke: 1'b0};
    vecs[2] = '{w: 24, h: 24, f0: 0,  f1: -1, poke: 1'b0};
    vecs[3] = '{w: 27, h: 24, f0: -1, f1: -1, poke: 1'b1};
    vecs[4] = '{w: 23, h: 40, f0: -1, f1: -1, poke: 1'b0};
    vecs[5] = '{w: 25, h: 26, f0: 3,  f1: -1, poke: 1'b0};
    n_vec = 0; n_bad = 0; cyc = 0;
    win_seen = 0; tgt0 = -1; tgt1 = -1; ncols_g = 1; last_win_cyc = 0; face_cyc = 0; pyr_starts = 0;
    stop_run = 1'b0; first_pushed = 1'b0; force_face = 1'b0; pend = '0;
    reset = 1'b1; laptop_img_rdy = 1'b0; pyr_ready = 1'b0;
    level_width = '0; level_height = '0; is_face = 1'b0;

    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    force_face = 1'b1;
    repeat (5) step();
    force_face = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);
    reset_mid_scan();
    run_scan(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
